// File: rtl/cic_decimator_pkg.sv
// cic_decimator_pkg
// Shared constants for the 4-stage, decimate-by-313 CIC filter:
// rate change, stage count, differential delay, bit growth, the DC
// normalisation gain and the output shift that goes with it.
package cic_decimator_pkg;

    localparam int CIC_R      = 313;   // decimation ratio
    localparam int CIC_N      = 4;     // integrator / comb stages
    localparam int CIC_M      = 1;     // comb differential delay
    localparam int CIC_B      = 34;    // ceil(N*log2(R)) bit growth
    localparam int CNT_WIDTH  = 9;     // holds 0..R-1

    // G ~= 2^51 / R^4, so (x * G) >>> 51 restores unity DC gain.
    localparam int                    GAIN_WIDTH = 18;
    localparam logic [GAIN_WIDTH-1:0] CIC_GAIN   = 18'd234614;
    localparam int                    OUT_SHIFT  = 51;

    // Full DC gain of the unnormalised CIC, used for the range check.
    localparam longint R_POW_N = longint'(CIC_R) * CIC_R * CIC_R * CIC_R;

    typedef logic [CNT_WIDTH-1:0] count_t;

    // Integrator / comb word width for a given sample width.
    function automatic int internal_width(input int sample_width);
        return sample_width + CIC_B;
    endfunction

endpackage

// File: rtl/cic_decimator_channel.sv
// cic_decimator_channel
// One real channel of the CIC decimator: integrators, combs, gain,
// rounding, saturation and overflow flags. Timing strobes come from the
// parent, which owns the decimation counter and valid pipeline.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_sample_valid          input sample accepted this cycle
//   i_dump                  this accepted sample completes a frame
//   i_comb_en .. i_out_en   one-hot walk of a decimated sample through
//                           the comb, gain, round and output stages
//   i_sample                signed input sample
//   o_sample                rounded/saturated output, held between strobes
//   o_pos/neg_oflow         final saturation hit (only with the out strobe)
//   o_cic_pos/neg_oflow     comb result outside the legal range
module cic_decimator_channel
    import cic_decimator_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_sample_valid,
    input  logic                    i_dump,
    input  logic                    i_comb_en,
    input  logic                    i_gain_en,
    input  logic                    i_round_en,
    input  logic                    i_out_en,
    input  logic signed [WIDTH-1:0] i_sample,
    output logic signed [WIDTH-1:0] o_sample,
    output logic                    o_pos_oflow,
    output logic                    o_neg_oflow,
    output logic                    o_cic_pos_oflow,
    output logic                    o_cic_neg_oflow
);

    localparam int IW = internal_width(WIDTH);      // integrator/comb width
    localparam int PW = IW + GAIN_WIDTH + 1;        // signed product width
    localparam int RW = PW - OUT_SHIFT;             // width after the shift

    localparam longint SAMPLE_MAX    = (longint'(1) <<< (WIDTH - 1)) - 1;
    localparam longint SAMPLE_MIN    = -(longint'(1) <<< (WIDTH - 1));
    localparam longint CIC_POS_LIMIT = SAMPLE_MAX * R_POW_N;
    localparam longint CIC_NEG_LIMIT = SAMPLE_MIN * R_POW_N;
    localparam logic signed [PW-1:0] ROUND_BIAS = PW'(1) <<< (OUT_SHIFT - 1);

    logic signed [IW-1:0] integ_q    [CIC_N];
    logic signed [IW-1:0] integ_d    [CIC_N];
    logic signed [IW-1:0] comb_dly_q [CIC_N][CIC_M];
    logic signed [IW-1:0] comb_dly_d [CIC_N][CIC_M];
    logic signed [IW-1:0] dec_q, dec_d;
    logic signed [IW-1:0] comb_q, comb_d;
    logic signed [PW-1:0] product_q, product_d;
    logic signed [RW-1:0] rounded_q, rounded_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic cic_pos_q, cic_pos_d, cic_neg_q, cic_neg_d;
    logic cic_pos_rnd_q, cic_pos_rnd_d, cic_neg_rnd_q, cic_neg_rnd_d;
    logic cic_pos_out_q, cic_pos_out_d, cic_neg_out_q, cic_neg_out_d;
    logic pos_out_q, pos_out_d, neg_out_q, neg_out_d;

    // Integrators run at the input rate. Each stage adds the freshly
    // updated value of the stage before it, so the frame's last sample is
    // already included in the value handed to the combs.
    always_comb begin
        integ_d = integ_q;
        if (i_sample_valid) begin
            integ_d[0] = integ_q[0] + IW'(i_sample);
            for (int k = 1; k < CIC_N; k++) begin
                integ_d[k] = integ_q[k] + integ_d[k-1];
            end
        end
        dec_d = i_dump ? integ_d[CIC_N-1] : dec_q;
    end

    // Comb chain at the decimated rate; all stages settle in one cycle.
    always_comb begin
        logic signed [IW-1:0] stage;
        stage      = dec_q;
        comb_dly_d = comb_dly_q;
        comb_d     = comb_q;
        if (i_comb_en) begin
            for (int k = 0; k < CIC_N; k++) begin
                comb_dly_d[k][0] = stage;
                for (int m = 1; m < CIC_M; m++) begin
                    comb_dly_d[k][m] = comb_dly_q[k][m-1];
                end
                stage = stage - comb_dly_q[k][CIC_M-1];
            end
            comb_d = stage;
        end
    end

    // Gain, round-half-up shift, then saturate. Range flags ride along.
    always_comb begin
        product_d     = product_q;
        cic_pos_d     = cic_pos_q;
        cic_neg_d     = cic_neg_q;
        rounded_d     = rounded_q;
        cic_pos_rnd_d = cic_pos_rnd_q;
        cic_neg_rnd_d = cic_neg_rnd_q;
        out_d         = out_q;
        pos_out_d     = 1'b0;
        neg_out_d     = 1'b0;
        cic_pos_out_d = 1'b0;
        cic_neg_out_d = 1'b0;

        if (i_gain_en) begin
            product_d = PW'(comb_q) * PW'(signed'({1'b0, CIC_GAIN}));
            cic_pos_d = longint'(comb_q) > CIC_POS_LIMIT;
            cic_neg_d = longint'(comb_q) < CIC_NEG_LIMIT;
        end

        if (i_round_en) begin
            rounded_d     = RW'((product_q + ROUND_BIAS) >>> OUT_SHIFT);
            cic_pos_rnd_d = cic_pos_q;
            cic_neg_rnd_d = cic_neg_q;
        end

        if (i_out_en) begin
            cic_pos_out_d = cic_pos_rnd_q;
            cic_neg_out_d = cic_neg_rnd_q;
            if (rounded_q > RW'(SAMPLE_MAX)) begin
                out_d     = WIDTH'(SAMPLE_MAX);
                pos_out_d = 1'b1;
            end else if (rounded_q < RW'(SAMPLE_MIN)) begin
                out_d     = WIDTH'(SAMPLE_MIN);
                neg_out_d = 1'b1;
            end else begin
                out_d = WIDTH'(rounded_q);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int k = 0; k < CIC_N; k++) begin
                integ_q[k] <= '0;
                for (int m = 0; m < CIC_M; m++) begin
                    comb_dly_q[k][m] <= '0;
                end
            end
            dec_q         <= '0;
            comb_q        <= '0;
            product_q     <= '0;
            rounded_q     <= '0;
            out_q         <= '0;
            cic_pos_q     <= 1'b0;
            cic_neg_q     <= 1'b0;
            cic_pos_rnd_q <= 1'b0;
            cic_neg_rnd_q <= 1'b0;
            cic_pos_out_q <= 1'b0;
            cic_neg_out_q <= 1'b0;
            pos_out_q     <= 1'b0;
            neg_out_q     <= 1'b0;
        end else begin
            integ_q       <= integ_d;
            comb_dly_q    <= comb_dly_d;
            dec_q         <= dec_d;
            comb_q        <= comb_d;
            product_q     <= product_d;
            rounded_q     <= rounded_d;
            out_q         <= out_d;
            cic_pos_q     <= cic_pos_d;
            cic_neg_q     <= cic_neg_d;
            cic_pos_rnd_q <= cic_pos_rnd_d;
            cic_neg_rnd_q <= cic_neg_rnd_d;
            cic_pos_out_q <= cic_pos_out_d;
            cic_neg_out_q <= cic_neg_out_d;
            pos_out_q     <= pos_out_d;
            neg_out_q     <= neg_out_d;
        end
    end

    assign o_sample        = out_q;
    assign o_pos_oflow     = pos_out_q;
    assign o_neg_oflow     = neg_out_q;
    assign o_cic_pos_oflow = cic_pos_out_q;
    assign o_cic_neg_oflow = cic_neg_out_q;

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator
// Complex (I/Q) CIC decimator, N=4, R=313, M=1, with unity DC gain,
// rounding, saturation and overflow flags. No backpressure.
//
// Ports:
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_inph, i_quad, i_valid     input I/Q samples and strobe
//   o_ready                     1 whenever not in reset
//   o_inph, o_quad, o_valid     decimated output, single-cycle strobe,
//                               4 cycles after the frame's last sample
//   o_*_pos/neg_oflow           saturation hit per channel
//   o_cic_*_pos/neg_oflow       comb range check per channel
module cic_decimator
    import cic_decimator_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic signed [WIDTH-1:0] i_inph,
    input  logic signed [WIDTH-1:0] i_quad,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic signed [WIDTH-1:0] o_inph,
    output logic signed [WIDTH-1:0] o_quad,
    output logic                    o_valid,
    output logic                    o_inph_pos_oflow,
    output logic                    o_inph_neg_oflow,
    output logic                    o_quad_pos_oflow,
    output logic                    o_quad_neg_oflow,
    output logic                    o_cic_inph_pos_oflow,
    output logic                    o_cic_inph_neg_oflow,
    output logic                    o_cic_quad_pos_oflow,
    output logic                    o_cic_quad_neg_oflow
);

    count_t     count_q, count_d;
    logic       dump;
    // Bit 0: frame captured; bits 1..3: comb/gain/round done; bit 4: output.
    logic [4:0] stage_q, stage_d;

    always_comb begin
        dump    = i_valid && (count_q == count_t'(CIC_R - 1));
        count_d = count_q;
        if (i_valid) begin
            count_d = dump ? '0 : count_q + 1'b1;
        end
        stage_d = {stage_q[3:0], dump};
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
            stage_q <= '0;
        end else begin
            count_q <= count_d;
            stage_q <= stage_d;
        end
    end

    assign o_ready = ~i_reset;
    assign o_valid = stage_q[4];

    cic_decimator_channel #(.WIDTH(WIDTH)) u_inph (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_sample_valid  (i_valid),
        .i_dump          (dump),
        .i_comb_en       (stage_q[0]),
        .i_gain_en       (stage_q[1]),
        .i_round_en      (stage_q[2]),
        .i_out_en        (stage_q[3]),
        .i_sample        (i_inph),
        .o_sample        (o_inph),
        .o_pos_oflow     (o_inph_pos_oflow),
        .o_neg_oflow     (o_inph_neg_oflow),
        .o_cic_pos_oflow (o_cic_inph_pos_oflow),
        .o_cic_neg_oflow (o_cic_inph_neg_oflow)
    );

    cic_decimator_channel #(.WIDTH(WIDTH)) u_quad (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_sample_valid  (i_valid),
        .i_dump          (dump),
        .i_comb_en       (stage_q[0]),
        .i_gain_en       (stage_q[1]),
        .i_round_en      (stage_q[2]),
        .i_out_en        (stage_q[3]),
        .i_sample        (i_quad),
        .o_sample        (o_quad),
        .o_pos_oflow     (o_quad_pos_oflow),
        .o_neg_oflow     (o_quad_neg_oflow),
        .o_cic_pos_oflow (o_cic_quad_pos_oflow),
        .o_cic_neg_oflow (o_cic_quad_neg_oflow)
    );

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator
// Self-checking bench. The reference model treats the filter as a plain
// FIR: each output is the sum of the last accepted samples weighted by
// the coefficients of (1 + z^-1 + ... + z^-312)^4, then scaled by
// G / 2^51 with round-half-up and saturation.
module tb_cic_decimator;

    localparam int     W       = 16;
    localparam int     R       = 313;
    localparam int     HLEN    = 4 * (R - 1) + 1;
    localparam longint GAIN    = 234614;
    localparam longint R4      = longint'(R) * R * R * R;
    localparam longint CIC_POS = 32767 * R4;
    localparam longint CIC_NEG = -32768 * R4;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    logic i_valid = 1'b0;
    logic signed [W-1:0] i_inph = '0;
    logic signed [W-1:0] i_quad = '0;
    logic o_ready, o_valid;
    logic signed [W-1:0] o_inph, o_quad;
    logic o_inph_pos_oflow, o_inph_neg_oflow, o_quad_pos_oflow, o_quad_neg_oflow;
    logic o_cic_inph_pos_oflow, o_cic_inph_neg_oflow, o_cic_quad_pos_oflow, o_cic_quad_neg_oflow;
    logic [7:0] flags_w;

    assign flags_w = {o_inph_pos_oflow, o_inph_neg_oflow, o_quad_pos_oflow, o_quad_neg_oflow,
                      o_cic_inph_pos_oflow, o_cic_inph_neg_oflow,
                      o_cic_quad_pos_oflow, o_cic_quad_neg_oflow};

    cic_decimator #(.WIDTH(W)) dut (
        .i_clock              (i_clock),
        .i_reset              (i_reset),
        .i_inph               (i_inph),
        .i_quad               (i_quad),
        .i_valid              (i_valid),
        .o_ready              (o_ready),
        .o_inph               (o_inph),
        .o_quad               (o_quad),
        .o_valid              (o_valid),
        .o_inph_pos_oflow     (o_inph_pos_oflow),
        .o_inph_neg_oflow     (o_inph_neg_oflow),
        .o_quad_pos_oflow     (o_quad_pos_oflow),
        .o_quad_neg_oflow     (o_quad_neg_oflow),
        .o_cic_inph_pos_oflow (o_cic_inph_pos_oflow),
        .o_cic_inph_neg_oflow (o_cic_inph_neg_oflow),
        .o_cic_quad_pos_oflow (o_cic_quad_pos_oflow),
        .o_cic_quad_neg_oflow (o_cic_quad_neg_oflow)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        int         cyc;
        int         i;
        int         q;
        logic [7:0] flags;
    } rec_t;

    longint h [HLEN];
    longint hist_i [$];
    longint hist_q [$];
    rec_t   exp_q [$];
    rec_t   obs_q [$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     frame_cnt = 0;
    int     stray_flags = 0;
    int     not_ready = 0;

    // Impulse response of four cascaded length-R boxcars.
    function automatic void build_coeffs();
        longint a [HLEN];
        longint b [HLEN];
        int     len;
        for (int j = 0; j < HLEN; j++) a[j] = (j < R) ? 64'sd1 : 64'sd0;
        len = R;
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < HLEN; j++) b[j] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++) b[i+j] += a[i];
            len += R - 1;
            a = b;
        end
        h = a;
    endfunction

    function automatic longint fir_sum(input longint hist [$]);
        longint y = 0;
        int     n = hist.size();
        for (int j = 0; j < HLEN && j < n; j++) y += h[j] * hist[n-1-j];
        return y;
    endfunction

    function automatic void scale(input longint y, output int o, output logic pos, output logic neg);
        logic signed [95:0] p;
        p   = 96'(y) * 96'(GAIN) + (96'sd1 <<< 50);
        p   = p >>> 51;
        pos = p > 96'sd32767;
        neg = p < -96'sd32768;
        o   = pos ? 32767 : (neg ? -32768 : int'(p[31:0]));
    endfunction

    function automatic void model_accept(input int si, input int sq);
        rec_t   e;
        longint yi, yq;
        logic   ip, in_, qp, qn;
        hist_i.push_back(longint'(si));
        hist_q.push_back(longint'(sq));
        if (hist_i.size() > HLEN) begin
            void'(hist_i.pop_front());
            void'(hist_q.pop_front());
        end
        frame_cnt++;
        if (frame_cnt == R) begin
            frame_cnt = 0;
            yi = fir_sum(hist_i);
            yq = fir_sum(hist_q);
            scale(yi, e.i, ip, in_);
            scale(yq, e.q, qp, qn);
            e.cyc   = cyc + 4;
            e.flags = {ip, in_, qp, qn, yi > CIC_POS, yi < CIC_NEG, yq > CIC_POS, yq < CIC_NEG};
            exp_q.push_back(e);
        end
    endfunction

    task automatic drive(input logic v, input int si, input int sq);
        rec_t r;
        i_valid = v;
        i_inph  = W'(si);
        i_quad  = W'(sq);
        @(posedge i_clock);
        cyc++;
        if (v) model_accept(si, sq);
        #1;
        if (o_ready !== 1'b1) not_ready++;
        if (o_valid === 1'b1) begin
            r.cyc   = cyc;
            r.i     = int'(o_inph);
            r.q     = int'(o_quad);
            r.flags = flags_w;
            obs_q.push_back(r);
        end else if (flags_w !== 8'h00) begin
            stray_flags++;
        end
    endtask

    task automatic apply_reset(input int n);
        i_reset = 1'b1;
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge i_clock);
            cyc++;
            #1;
        end
        i_reset = 1'b0;
        hist_i.delete();
        hist_q.delete();
        exp_q.delete();
        obs_q.delete();
        frame_cnt = 0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_valid = 1'b1;
        i_inph  = 16'sd1234;
        i_quad  = -16'sd99;
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clock);
            cyc++;
            #1;
            total++;
            if ({o_ready, o_valid, o_inph, o_quad, flags_w} !== 42'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got ready=%b valid=%b i=%0d q=%0d flags=%b required all 0",
                         k, o_ready, o_valid, o_inph, o_quad, flags_w);
            end
        end
        apply_reset(1);
        for (int k = 0; k < 100; k++) drive(1'b0, 777, -777);
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL idle_strobes: got %0d required 0", obs_q.size());
        end
        total++;
        if (o_inph !== '0 || o_quad !== '0) begin
            bad++;
            $display("FAIL idle_outputs: got i=%0d q=%0d required 0 0", o_inph, o_quad);
        end
        total++;
        if (not_ready != 0) begin
            bad++;
            $display("FAIL idle_ready: got %0d low cycles required 0", not_ready);
        end
        $display("reset/idle: %0d cycles, strobes=%0d", cyc, obs_q.size());
    endtask

    task automatic test_dc_const();
        for (int k = 0; k < R * 20; k++) drive(1'b1, 16384, -16384);
        repeat (8) drive(1'b0, 0, 0);
        total++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 20) begin
            bad++;
            $display("FAIL dc_count: got %0d required %0d (20)", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            $display("dc strobe %0d cyc=%0d i=%0d q=%0d flags=%b", k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags);
            total++;
            if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].i != exp_q[k].i ||
                obs_q[k].q != exp_q[k].q || obs_q[k].flags !== exp_q[k].flags) begin
                bad++;
                $display("FAIL dc_model %0d: got cyc=%0d i=%0d q=%0d f=%b required cyc=%0d i=%0d q=%0d f=%b",
                         k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags,
                         exp_q[k].cyc, exp_q[k].i, exp_q[k].q, exp_q[k].flags);
            end
            if (k >= 4) begin
                total++;
                if (obs_q[k].i < 16383 || obs_q[k].i > 16385 || obs_q[k].q < -16385 || obs_q[k].q > -16383) begin
                    bad++;
                    $display("FAIL dc_gain %0d: got i=%0d q=%0d required 16384+-1 -16384+-1", k, obs_q[k].i, obs_q[k].q);
                end
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_full_scale();
        int val;
        for (int ph = 0; ph < 2; ph++) begin
            val = (ph == 0) ? 32767 : -32768;
            for (int k = 0; k < R * 10; k++) drive(1'b1, val, val);
            repeat (8) drive(1'b0, 0, 0);
            total++;
            if (obs_q.size() != exp_q.size()) begin
                bad++;
                $display("FAIL fs_count: got %0d required %0d", obs_q.size(), exp_q.size());
            end
            for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
                $display("full-scale %0d strobe %0d cyc=%0d i=%0d q=%0d flags=%b", val, k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags);
                total++;
                if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].i != exp_q[k].i ||
                    obs_q[k].q != exp_q[k].q || obs_q[k].flags !== exp_q[k].flags) begin
                    bad++;
                    $display("FAIL fs_model %0d: got cyc=%0d i=%0d q=%0d f=%b required cyc=%0d i=%0d q=%0d f=%b",
                             k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags,
                             exp_q[k].cyc, exp_q[k].i, exp_q[k].q, exp_q[k].flags);
                end
                if (k >= 4) begin
                    total++;
                    if (obs_q[k].i != val || obs_q[k].q != val || obs_q[k].flags !== 8'h00) begin
                        bad++;
                        $display("FAIL fs_value %0d: got i=%0d q=%0d f=%b required %0d %0d 00000000",
                                 k, obs_q[k].i, obs_q[k].q, obs_q[k].flags, val, val);
                    end
                end
            end
            exp_q.delete();
            obs_q.delete();
        end
    endtask

    task automatic test_random_gaps();
        int   accepted = 0;
        logic v;
        while (accepted < R * 12) begin
            v = ($urandom_range(9) < 7);
            drive(v, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
            if (v) accepted++;
        end
        repeat (8) drive(1'b0, 0, 0);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            $display("random strobe %0d cyc=%0d i=%0d q=%0d flags=%b", k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags);
            total++;
            if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].i != exp_q[k].i ||
                obs_q[k].q != exp_q[k].q || obs_q[k].flags !== exp_q[k].flags) begin
                bad++;
                $display("FAIL rand_model %0d: got cyc=%0d i=%0d q=%0d f=%b required cyc=%0d i=%0d q=%0d f=%b",
                         k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags,
                         exp_q[k].cyc, exp_q[k].i, exp_q[k].q, exp_q[k].flags);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_stopband_tone();
        real ph;
        for (int n = 0; n < R * 25; n++) begin
            ph = 2.0 * 3.14159265358979 * 0.9 * real'(n) / 313.0;
            drive(1'b1, int'(32767.0 * $cos(ph)), int'(32767.0 * $sin(ph)));
        end
        repeat (8) drive(1'b0, 0, 0);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL tone_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            $display("tone strobe %0d cyc=%0d i=%0d q=%0d flags=%b", k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags);
            total++;
            if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].i != exp_q[k].i ||
                obs_q[k].q != exp_q[k].q || obs_q[k].flags !== exp_q[k].flags) begin
                bad++;
                $display("FAIL tone_model %0d: got cyc=%0d i=%0d q=%0d f=%b required cyc=%0d i=%0d q=%0d f=%b",
                         k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags,
                         exp_q[k].cyc, exp_q[k].i, exp_q[k].q, exp_q[k].flags);
            end
            if (k >= 4) begin
                total++;
                if (obs_q[k].i * obs_q[k].i + obs_q[k].q * obs_q[k].q > 256) begin
                    bad++;
                    $display("FAIL tone_atten %0d: got i=%0d q=%0d required magnitude <= 16", k, obs_q[k].i, obs_q[k].q);
                end
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_half_duty();
        for (int k = 0; k < R * 8; k++) begin
            drive(1'b1, 1000, 1000);
            drive(1'b0, -5, 5);
        end
        repeat (8) drive(1'b0, 0, 0);
        total++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 8) begin
            bad++;
            $display("FAIL duty_count: got %0d required %0d (8)", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            $display("half-duty strobe %0d cyc=%0d i=%0d q=%0d flags=%b", k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags);
            total++;
            if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].i != exp_q[k].i ||
                obs_q[k].q != exp_q[k].q || obs_q[k].flags !== exp_q[k].flags) begin
                bad++;
                $display("FAIL duty_model %0d: got cyc=%0d i=%0d q=%0d f=%b required cyc=%0d i=%0d q=%0d f=%b",
                         k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags,
                         exp_q[k].cyc, exp_q[k].i, exp_q[k].q, exp_q[k].flags);
            end
            if (k >= 4) begin
                total++;
                if (obs_q[k].i != 1000 || obs_q[k].q != 1000 || obs_q[k].cyc - obs_q[k-1].cyc != 2 * R) begin
                    bad++;
                    $display("FAIL duty_value %0d: got i=%0d q=%0d spacing=%0d required 1000 1000 %0d",
                             k, obs_q[k].i, obs_q[k].q, obs_q[k].cyc - obs_q[k-1].cyc, 2 * R);
                end
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 150; k++) drive(1'b1, 5000, -5000);
        apply_reset(2);
        for (int k = 0; k < R; k++) drive(1'b1, 5000, -5000);
        repeat (8) drive(1'b0, 0, 0);
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++;
            $display("FAIL midreset_count: got %0d required 1", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            $display("mid-reset strobe %0d cyc=%0d i=%0d q=%0d flags=%b", k, obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags);
            total++;
            if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].i != exp_q[k].i ||
                obs_q[k].q != exp_q[k].q || obs_q[k].flags !== exp_q[k].flags) begin
                bad++;
                $display("FAIL midreset_model: got cyc=%0d i=%0d q=%0d f=%b required cyc=%0d i=%0d q=%0d f=%b",
                         obs_q[k].cyc, obs_q[k].i, obs_q[k].q, obs_q[k].flags,
                         exp_q[k].cyc, exp_q[k].i, exp_q[k].q, exp_q[k].flags);
            end
        end
        exp_q.delete();
        obs_q.delete();
        total++;
        if (stray_flags != 0) begin
            bad++;
            $display("FAIL stray_flags: got %0d flagged cycles without o_valid required 0", stray_flags);
        end
        total++;
        if (not_ready != 0) begin
            bad++;
            $display("FAIL ready_low: got %0d cycles required 0", not_ready);
        end
    endtask

    initial begin
        build_coeffs();
        test_reset();
        test_dc_const();
        test_full_scale();
        test_random_gaps();
        test_stopband_tone();
        test_half_duty();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
Complex (I/Q) fixed-ratio CIC decimation filter, decimate by 313. It sits after a baseband mixer/ADC front end, reducing a full-rate I/Q stream to the channel rate. A constant gain multiply normalises DC gain to unity. Outputs are rounded and saturated to WIDTH bits, with overflow status flags.

Parameters:
WIDTH, 16, input/output sample width (signed two's complement) for each of I and Q.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_inph  in  WIDTH  in-phase input sample, signed
i_quad  in  WIDTH  quadrature input sample, signed
i_valid  in  1  input sample strobe
o_ready  out  1  input accept; 0 in reset, 1 otherwise
o_inph  out  WIDTH  decimated in-phase output, signed
o_quad  out  WIDTH  decimated quadrature output, signed
o_valid  out  1  single-cycle output strobe
o_inph_pos_oflow / o_inph_neg_oflow  out  1 each  I final saturation hit (high/low)
o_quad_pos_oflow / o_quad_neg_oflow  out  1 each  Q final saturation hit
o_cic_inph_pos_oflow / o_cic_inph_neg_oflow  out  1 each  I CIC range check failed
o_cic_quad_pos_oflow / o_cic_quad_neg_oflow  out  1 each  Q CIC range check failed

Behaviour:
- Reset: synchronous, active-high on i_clock. Clears integrators, combs, decimation counter and pipeline. All outputs 0 (o_ready 0).
- Reset asserted mid-operation discards the partial decimation frame. The counter phase restarts at zero after reset.
- Filter structure: N=4 stages, R=313, differential delay M=1.
- Bit growth B = ceil(4*log2(313)) = 34. Internal width is WIDTH+34 = 50, with modular (wrapping) arithmetic.
- Each channel is independent and identical.
- Integrators: sign-extended input. All 4 integrators update only on cycles with i_valid=1. No update when i_valid=0 (gaps allowed).
- Decimation counter 0..312 advances per accepted sample. On the 313th accepted sample of each frame (count wraps 312->0), the last integrator value is passed to the comb chain.
- Output count = floor(accepted samples / 313). Examples: 1079539 inputs -> 3449 outputs; 1252000 -> 4000.
- Combs: 4 cascaded y[k]=x[k]-x[k-1] at the decimated rate. Comb state advances only on decimated samples.
- Gain: comb result (50-bit signed) times G=234614 (18-bit unsigned, approximately 2^51/313^4).
- Scaling: round half up by adding 2^50, then arithmetic shift right 51, then saturate to WIDTH bits.
- Saturation: if the result exceeds 2^(WIDTH-1)-1, output max and pulse *_pos_oflow. If it is below -2^(WIDTH-1), output min and pulse *_neg_oflow.
- CIC check: o_cic_*_pos_oflow pulses if comb output > (2^(WIDTH-1)-1)*313^4. o_cic_*_neg_oflow pulses if comb output < -2^(WIDTH-1)*313^4. This cannot happen with legal input; it is a sanity check.
- All oflow flags are valid only together with o_valid and are 0 otherwise.
- Latency: o_valid asserts exactly 4 cycles after the clock edge accepting the frame's 313th sample, for one cycle.
- o_inph/o_quad hold their last value between strobes.
- No backpressure: o_ready=1 whenever not in reset; the i_valid pulse pattern is unconstrained.
- Frequency response: sinc^4.
  - DC gain 1.0 (within 0.01%).
  - A tone at 0.9/313 cycles/sample is attenuated more than 66 dB.
  - Passband |f| < 0.25/313 is not droop-compensated.

Decomposition:
- Package cic_decimator_pkg: constants R=313, N=4, M=1, B=34, internal width, G=234614, shift 51.
- Sub-module cic_decimator_channel: integrators, combs, gain, round, saturate and flags for one real channel. Instantiated twice (I, Q).
- The decimation counter and o_valid pipeline are shared in the top level.

Test Plan:
- Reset, then i_valid=0 for 100 cycles -> o_valid never asserts; all outputs 0.
- Constant I=16384, Q=-16384 for 313*20 samples -> 20 strobes; after 4 settling outputs, I=16384±1 and Q=-16384±1; no oflow flags.
- Full-scale complex tone at 0.01/313 (amplitude 32767, rounded), 1079539 samples -> exactly 3449 strobes. After settling: |out| > 4096, and per-output phase advance = 2π·0.01 ± 1e-5 rad.
- Tone at 0.9/313, 313*4000 samples -> 4000 strobes; magnitude ≤ 16 after settling.
- I=Q=32767 DC -> output 32767, no pos_oflow. I=Q=-32768 DC -> output -32768, no neg_oflow. No CIC flags in either case.
- i_valid toggling 50% duty with DC 1000 -> one strobe per 313 accepted samples, same value as continuous valid. Reset pulse mid-frame followed by 313 samples -> exactly one strobe.
